// File: rtl/mem_req_arb.sv
// mem_req_arb: arbitrates an instruction-fetch port and a load/store port onto a single
// downstream memory request channel. At most one transaction is outstanding. Data requests
// win by default; an instruction request that has watched StarveMax consecutive data
// grants wins the next arbitration.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   inst_req_i/inst_addr_i   fetch request, held until inst_addr_ok_o
//   inst_addr_ok_o           fetch accepted downstream (pulse)
//   inst_valid_o/inst_rdata_o  fetch data valid (pulse) / fetch data
//   data_req_i, data_wr_i, data_wstrb_i, data_addr_i, data_wdata_i
//                            load/store request, held until data_addr_ok_o
//   data_addr_ok_o           load/store accepted downstream (pulse)
//   data_data_ok_o/data_rdata_o  load data valid or store done (pulse) / load data
//   mem_req_o, mem_wr_o, mem_wstrb_o, mem_addr_o, mem_wdata_o  downstream request
//   mem_addr_ok_i, mem_data_ok_i, mem_rdata_i                   downstream response
module mem_req_arb #(
  parameter int unsigned StarveMax = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_addr_ok_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_rdata_o,

  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,

  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } state_e;

  typedef enum logic {
    OwnInst = 1'b0,
    OwnData = 1'b1
  } owner_e;

  localparam logic [2:0] StarveLim = 3'(StarveMax);
  localparam logic [2:0] StarveSat = 3'd7;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [2:0] starve_q, starve_d;

  logic inst_forced;
  logic grant_data;
  logic grant_inst;
  logic owner_req;
  logic addr_ok;
  logic resp_ok;

  // Arbitration: data first unless the fetch side has hit its starvation limit.
  assign inst_forced = inst_req_i && (starve_q == StarveLim);
  assign grant_data  = data_req_i && !inst_forced;
  assign grant_inst  = inst_req_i && !grant_data;

  // Live request line of whichever side owns the channel.
  assign owner_req = (owner_q == OwnData) ? data_req_i : inst_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= OwnInst;
      starve_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    mem_req_o = 1'b0;
    addr_ok   = 1'b0;
    resp_ok   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          owner_d = OwnData;
          state_d = StReq;
          // Only data grants that overtake a waiting fetch count toward starvation.
          if (inst_req_i && (starve_q != StarveSat)) begin
            starve_d = starve_q + 3'd1;
          end
        end else if (grant_inst) begin
          owner_d  = OwnInst;
          starve_d = 3'd0;
          state_d  = StReq;
        end
      end

      StReq: begin
        if (mem_addr_ok_i) begin
          // Accept wins over a simultaneous mem_data_ok, which is ignored here.
          mem_req_o = 1'b1;
          addr_ok   = 1'b1;
          state_d   = StResp;
        end else if (!owner_req) begin
          // Requester withdrew before acceptance: drop the request this cycle.
          state_d = StIdle;
        end else begin
          mem_req_o = 1'b1;
        end
      end

      StResp: begin
        if (mem_data_ok_i) begin
          resp_ok = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Downstream fields follow the owner's live inputs; a fetch is always a full read.
  always_comb begin
    if (owner_q == OwnData) begin
      mem_wr_o    = data_wr_i;
      mem_wstrb_o = data_wstrb_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_wr_o    = 1'b0;
      mem_wstrb_o = 4'h0;
      mem_addr_o  = inst_addr_i;
      mem_wdata_o = 32'h0;
    end
  end

  assign inst_addr_ok_o = addr_ok && (owner_q == OwnInst);
  assign data_addr_ok_o = addr_ok && (owner_q == OwnData);
  assign inst_valid_o   = resp_ok && (owner_q == OwnInst);
  assign data_data_ok_o = resp_ok && (owner_q == OwnData);

  // Read data is a straight pass-through; consumers qualify it with their valid pulse.
  assign inst_rdata_o = mem_rdata_i;
  assign data_rdata_o = mem_rdata_i;

`ifndef SYNTHESIS
  a_addr_ok_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(inst_addr_ok_o && data_addr_ok_o));
  a_resp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(inst_valid_o && data_data_ok_o));
  a_no_req_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StResp) |-> !mem_req_o);
`endif

endmodule

// File: tb/tb_mem_req_arb.sv
module tb_mem_req_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_addr_ok, inst_valid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_req_arb #(.StarveMax(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .inst_req_i     (inst_req),
    .inst_addr_i    (inst_addr),
    .inst_addr_ok_o (inst_addr_ok),
    .inst_valid_o   (inst_valid),
    .inst_rdata_o   (inst_rdata),
    .data_req_i     (data_req),
    .data_wr_i      (data_wr),
    .data_wstrb_i   (data_wstrb),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_addr_ok_o (data_addr_ok),
    .data_data_ok_o (data_data_ok),
    .data_rdata_o   (data_rdata),
    .mem_req_o      (mem_req),
    .mem_wr_o       (mem_wr),
    .mem_wstrb_o    (mem_wstrb),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_addr_ok_i  (mem_addr_ok),
    .mem_data_ok_i  (mem_data_ok),
    .mem_rdata_i    (mem_rdata)
  );

  typedef struct {
    bit          is_resp;
    bit          own_data;
    logic [31:0] addr;
    bit          wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void push_addr(bit d, logic [31:0] a, bit wr, logic [3:0] s,
                                    logic [31:0] w);
    exp_t e;
    e.is_resp = 1'b0; e.own_data = d; e.addr = a; e.wr = wr; e.wstrb = s;
    e.wdata = w; e.rdata = 32'h0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_resp(bit d, logic [31:0] r);
    exp_t e;
    e.is_resp = 1'b1; e.own_data = d; e.addr = 32'h0; e.wr = 1'b0; e.wstrb = 4'h0;
    e.wdata = 32'h0; e.rdata = r;
    exp_q.push_back(e);
  endfunction

  // Monitor: every handshake pulse the DUT presents is matched against the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    if (inst_addr_ok || data_addr_ok) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL addr_ok: unexpected pulse inst=%0b data=%0b, required none",
                 inst_addr_ok, data_addr_ok);
      end else begin
        e  = exp_q.pop_front();
        ok = !e.is_resp && (data_addr_ok == e.own_data) && (inst_addr_ok == !e.own_data)
             && mem_req && (mem_addr == e.addr) && (mem_wr == e.wr)
             && (mem_wstrb == e.wstrb) && (!e.wr || (mem_wdata == e.wdata));
        if (!ok) begin
          fails++;
          $display("FAIL addr_ok: got inst=%0b data=%0b req=%0b addr=%h wr=%0b strb=%h wd=%h; required resp_kind=%0b data=%0b addr=%h wr=%0b strb=%h wd=%h",
                   inst_addr_ok, data_addr_ok, mem_req, mem_addr, mem_wr, mem_wstrb,
                   mem_wdata, e.is_resp, e.own_data, e.addr, e.wr, e.wstrb, e.wdata);
        end
      end
    end
    if (inst_valid || data_data_ok) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL response: unexpected pulse inst_valid=%0b data_ok=%0b, required none",
                 inst_valid, data_data_ok);
      end else begin
        e  = exp_q.pop_front();
        ok = e.is_resp && (data_data_ok == e.own_data) && (inst_valid == !e.own_data)
             && ((e.own_data ? data_rdata : inst_rdata) == e.rdata);
        if (!ok) begin
          fails++;
          $display("FAIL response: got inst_valid=%0b data_ok=%0b irdata=%h drdata=%h; required resp_kind=%0b data=%0b rdata=%h",
                   inst_valid, data_data_ok, inst_rdata, data_rdata, e.is_resp,
                   e.own_data, e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pulses();
    return {28'h0, inst_addr_ok, inst_valid, data_addr_ok, data_data_ok};
  endfunction

  task automatic wait_req(string name);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(mem_req), 32'h1);
  endtask

  // Downstream model: accept after aw REQ cycles, complete after dw further RESP cycles.
  task automatic run_txn(int aw, int dw, logic [31:0] rd, bit drop_i, bit drop_d,
                         string name);
    wait_req(name);
    repeat (aw) tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    if (drop_i) inst_req = 1'b0;
    if (drop_d) data_req = 1'b0;
    repeat (dw) tick();
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    tick();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset mem_req", 32'(mem_req), 32'h0);
    check("reset pulses", pulses(), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single fetch, with a stray mem_data_ok while in REQ.
    push_addr(1'b0, 32'h1C00_0000, 1'b0, 4'h0, 32'h0);
    push_resp(1'b0, 32'h0280_0400);
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0000;
    wait_req("fetch mem_req");
    check("fetch mem_addr", mem_addr, 32'h1C00_0000);
    check("fetch mem_wr", 32'(mem_wr), 32'h0);
    mem_data_ok = 1'b1;
    tick();
    mem_data_ok = 1'b0;
    check("data_ok in REQ ignored", 32'(mem_req), 32'h1);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    inst_req    = 1'b0;
    tick(); tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0280_0400;
    tick();
    mem_data_ok = 1'b0;
    tick();

    // Simultaneous addr_ok and data_ok in REQ counts as accept only.
    push_addr(1'b0, 32'h1C00_0008, 1'b0, 4'h0, 32'h0);
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0008;
    wait_req("simul mem_req");
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_0BAD;
    #1;
    check("simul no valid", 32'(inst_valid), 32'h0);
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    inst_req    = 1'b0;
    check("simul in RESP no mem_req", 32'(mem_req), 32'h0);
    push_resp(1'b0, 32'h3333_3333);
    tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3333_3333;
    tick();
    mem_data_ok = 1'b0;
    tick();

    // Contention: store beats fetch, fetch follows.
    push_addr(1'b1, 32'h0000_0100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    push_resp(1'b1, 32'h0);
    push_addr(1'b0, 32'h1C00_0004, 1'b0, 4'h0, 32'h0);
    push_resp(1'b0, 32'h1111_1111);
    inst_req   = 1'b1;
    inst_addr  = 32'h1C00_0004;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h0000_0100;
    data_wstrb = 4'hF;
    data_wdata = 32'hDEAD_BEEF;
    run_txn(1, 1, 32'h0, 1'b0, 1'b1, "contention data");
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    run_txn(0, 2, 32'h1111_1111, 1'b1, 1'b0, "contention inst");
    tick();

    // Abort: load withdrawn in REQ, waiting fetch goes next.
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_000C;
    data_req  = 1'b1;
    data_addr = 32'h0000_0300;
    wait_req("abort mem_req");
    check("abort owner addr", mem_addr, 32'h0000_0300);
    data_req = 1'b0;
    #1;
    check("abort mem_req drop", 32'(mem_req), 32'h0);
    tick();
    push_addr(1'b0, 32'h1C00_000C, 1'b0, 4'h0, 32'h0);
    push_resp(1'b0, 32'h2222_2222);
    run_txn(0, 0, 32'h2222_2222, 1'b1, 1'b0, "abort then inst");
    tick();

    // Reset in RESP after a data grant that bumped the starvation count.
    push_addr(1'b1, 32'h0000_0400, 1'b0, 4'h0, 32'h0);
    inst_req  = 1'b1;
    data_req  = 1'b1;
    data_addr = 32'h0000_0400;
    wait_req("rst txn mem_req");
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    rst_n       = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h4444_4444;
    #1;
    check("rst mid-RESP pulses", pulses(), 32'h0);
    check("rst mid-RESP mem_req", 32'(mem_req), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-rst data_ok ignored", pulses(), 32'h0);
    mem_data_ok = 1'b0;
    tick();
    check("post-rst idle", 32'(mem_req), 32'h0);

    // Spurious completion in IDLE.
    mem_data_ok = 1'b1;
    #1;
    check("idle data_ok pulses", pulses(), 32'h0);
    tick();
    check("idle data_ok state", 32'(mem_req), 32'h0);
    mem_data_ok = 1'b0;
    tick();

    // Starvation limit: D,D,D,D,I,D,D,D,D,I with both requests held.
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0010;
    data_req  = 1'b1;
    data_addr = 32'h0000_0500;
    for (int i = 0; i < 10; i++) begin
      bit d;
      d = !(i == 4 || i == 9);
      push_addr(d, d ? 32'h0000_0500 : 32'h1C00_0010, 1'b0, 4'h0, 32'h0);
      push_resp(d, 32'(32'h1000 + i));
    end
    for (int i = 0; i < 10; i++) begin
      run_txn(0, 0, 32'(32'h1000 + i), i == 9, i == 9, "starve txn");
    end

    repeat (3) tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
